// File: rtl/ac1_seq_ctrl.sv
// Sequencer for the bit-serial activation shift-accumulate register.
// Each vector gets one clear-load cycle followed by Pa-1 shift-accumulate
// cycles. The result is then held under a valid/ready handshake. A job
// covers n_vec vectors and is started by a single start pulse.
module ac1_seq_ctrl #(
    parameter int Pa   = 8,
    parameter int M    = 16,
    parameter int NV_W = 8,
    localparam int BW  = (Pa > 1) ? $clog2(Pa) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NV_W-1:0] n_vec,
    input  logic            ps_valid,
    output logic            ps_ready,
    output logic            cl_en,
    output logic            w_en,
    output logic            s_en,
    output logic [BW-1:0]   bit_idx,
    output logic            msb_flag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NV_W-1:0] vec_idx,
    output logic            busy,
    output logic            done
);

    // Elaboration guard: a single-bit vector has no shift phase.
    if (Pa < 2 || M < 1) begin : g_bad_param
        $error("ac1_seq_ctrl: Pa must be >= 2 and M >= 1");
    end

    localparam logic [BW-1:0] LAST_BIT = BW'(Pa - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic [NV_W-1:0] vec_idx_q, vec_idx_d;
    logic [NV_W-1:0] n_vec_q, n_vec_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            vec_idx_q   <= '0;
            n_vec_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            vec_idx_q   <= vec_idx_d;
            n_vec_q     <= n_vec_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic and combinational register enables. Enables depend
    // on ps_valid directly so the register captures the partial sum in the
    // same cycle it is offered; cl_en is only ever raised together with w_en.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        vec_idx_d   = vec_idx_q;
        n_vec_d     = n_vec_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        ps_ready    = 1'b0;
        cl_en       = 1'b0;
        w_en        = 1'b0;
        s_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_vec != '0) begin
                        n_vec_d   = n_vec;
                        vec_idx_d = '0;
                        bit_idx_d = '0;
                        state_d   = LOAD;
                    end else begin
                        // Empty job completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                ps_ready = 1'b1;
                if (ps_valid) begin
                    cl_en     = 1'b1;
                    w_en      = 1'b1;
                    bit_idx_d = BW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                ps_ready = 1'b1;
                if (ps_valid) begin
                    w_en = 1'b1;
                    s_en = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d   = '0;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (vec_idx_q == n_vec_q - NV_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        vec_idx_d = vec_idx_q + NV_W'(1);
                        state_d   = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bit_idx   = bit_idx_q;
    assign msb_flag  = (bit_idx_q == LAST_BIT);
    assign out_valid = out_valid_q;
    assign vec_idx   = vec_idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_ac1_seq_ctrl.sv
// Directed bench for ac1_seq_ctrl (Pa=8, NV_W=8).
module tb_ac1_seq_ctrl;

    localparam int PA   = 8;
    localparam int NV_W = 8;

    logic            clk = 1'b0;
    logic            rst, start, ps_valid, out_ready;
    logic [NV_W-1:0] n_vec;
    logic            ps_ready, cl_en, w_en, s_en, msb_flag, out_valid, busy, done;
    logic [2:0]      bit_idx;
    logic [NV_W-1:0] vec_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ac1_seq_ctrl #(.Pa(PA), .M(16), .NV_W(NV_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_vec(n_vec),
        .ps_valid(ps_valid), .ps_ready(ps_ready), .cl_en(cl_en), .w_en(w_en),
        .s_en(s_en), .bit_idx(bit_idx), .msb_flag(msb_flag),
        .out_valid(out_valid), .out_ready(out_ready), .vec_idx(vec_idx),
        .busy(busy), .done(done)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run the clock until the job ends, then clear the done pulse.
    task automatic drain();
        int i;
        for (i = 0; i < 200 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_timeout busy=%b want 0", busy);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n_vec = '0; ps_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, ps_ready, cl_en, w_en, s_en, bit_idx, vec_idx} !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b ov=%b rdy=%b en=%b%b%b bit=%0d vec=%0d want all 0",
                     busy, done, out_valid, ps_ready, cl_en, w_en, s_en, bit_idx, vec_idx);
        end
    endtask

    task automatic test_basic();
        start = 1'b1; n_vec = 8'd1; ps_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        #1;
        checks++;
        if ({cl_en, w_en, s_en, ps_ready, busy, bit_idx} !== {5'b11011, 3'd0}) begin
            failures++;
            $display("FAIL basic_load got cl/w/s/rdy/busy=%b%b%b%b%b bit=%0d want 11011 bit=0",
                     cl_en, w_en, s_en, ps_ready, busy, bit_idx);
        end
        tick();
        for (int k = 1; k < PA; k++) begin
            checks++;
            if ({cl_en, w_en, s_en, bit_idx, msb_flag} !== {3'b011, 3'(k), (k == PA-1)}) begin
                failures++;
                $display("FAIL basic_shift%0d got cl/w/s=%b%b%b bit=%0d msb=%b want 011 bit=%0d msb=%b",
                         k, cl_en, w_en, s_en, bit_idx, msb_flag, k, (k == PA-1));
            end
            tick();
        end
        checks++;
        if ({out_valid, w_en, ps_ready, done} !== 4'b1000) begin
            failures++;
            $display("FAIL basic_out got ov/w/rdy/done=%b%b%b%b want 1000", out_valid, w_en, ps_ready, done);
        end
        tick();
        checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL basic_done got done/busy/ov=%b%b%b want 100", done, busy, out_valid);
        end
        // start coincident with done: state is IDLE so it is accepted.
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        checks++;
        if ({cl_en, busy, done} !== 3'b110) begin
            failures++;
            $display("FAIL back_to_back_start got cl/busy/done=%b%b%b want 110", cl_en, busy, done);
        end
        drain();
    endtask

    task automatic test_stalls();
        int acc = 0;
        int ens = 0;
        int c;
        start = 1'b1; n_vec = 8'd1; ps_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (c = 0; c < 60 && !out_valid; c++) begin
            ps_valid = (c % 3 == 0);
            #1;
            checks++;
            if ({bit_idx, cl_en, w_en, s_en} !==
                {3'(acc), ps_valid && acc == 0, ps_valid, ps_valid && acc != 0}) begin
                failures++;
                $display("FAIL stall_c%0d got bit=%0d cl/w/s=%b%b%b want bit=%0d pv=%b",
                         c, bit_idx, cl_en, w_en, s_en, acc, ps_valid);
            end
            if (w_en) ens++;
            if (ps_valid) acc++;
            tick();
        end
        ps_valid = 1'b1;
        #1;
        checks++;
        if (ens !== PA || out_valid !== 1'b1 || w_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_total got ens=%0d ov=%b w=%b want ens=%0d ov=1 w=0", ens, out_valid, w_en, PA);
        end
        drain();
    endtask

    task automatic test_backpressure();
        start = 1'b1; n_vec = 8'd3; ps_valid = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int v = 0; v < 3; v++) begin
            for (int b = 0; b < PA; b++) begin
                checks++;
                if (w_en !== 1'b1 || vec_idx !== 8'(v) || cl_en !== (b == 0)) begin
                    failures++;
                    $display("FAIL bp_feed v%0d b%0d got w=%b cl=%b vec=%0d want w=1 cl=%b vec=%0d",
                             v, b, w_en, cl_en, vec_idx, (b == 0), v);
                end
                tick();
            end
            for (int j = 0; j < 5; j++) begin
                checks++;
                if ({out_valid, w_en, s_en, cl_en, ps_ready, done} !== 6'b100000 || vec_idx !== 8'(v)) begin
                    failures++;
                    $display("FAIL bp_hold v%0d j%0d got ov/w/s/cl/rdy/done=%b%b%b%b%b%b vec=%0d want 100000 vec=%0d",
                             v, j, out_valid, w_en, s_en, cl_en, ps_ready, done, vec_idx, v);
                end
                tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        #1;
        checks++;
        if ({done, busy, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL bp_done got done/busy/ov=%b%b%b want 100", done, busy, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_done got done=%b want 0", done);
        end
    endtask

    task automatic test_zero_len();
        start = 1'b1; n_vec = 8'd0; ps_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        #1;
        checks++;
        if ({done, busy, cl_en, w_en, s_en, ps_ready} !== 6'b100000) begin
            failures++;
            $display("FAIL zero_len got done/busy/cl/w/s/rdy=%b%b%b%b%b%b want 100000",
                     done, busy, cl_en, w_en, s_en, ps_ready);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL zero_len_after got done/busy=%b%b want 00", done, busy);
        end
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1; n_vec = 8'd2; ps_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < PA + 1 + 4; i++) tick();
        checks++;
        if (bit_idx !== 3'd4 || vec_idx !== 8'd1 || s_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_pos got bit=%0d vec=%0d s=%b want bit=4 vec=1 s=1", bit_idx, vec_idx, s_en);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, ps_ready, cl_en, w_en, s_en, msb_flag, bit_idx, vec_idx} !== '0) begin
            failures++;
            $display("FAIL mid_reset got busy=%b done=%b ov=%b rdy=%b en=%b%b%b bit=%0d vec=%0d want all 0",
                     busy, done, out_valid, ps_ready, cl_en, w_en, s_en, bit_idx, vec_idx);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_nodone got done=%b want 0", done);
        end
        start = 1'b1; n_vec = 8'd1;
        tick();
        start = 1'b0;
        #1;
        checks++;
        if ({cl_en, w_en, busy} !== 3'b111 || vec_idx !== 8'd0 || bit_idx !== 3'd0) begin
            failures++;
            $display("FAIL mid_restart got cl/w/busy=%b%b%b vec=%0d bit=%0d want 111 vec=0 bit=0",
                     cl_en, w_en, busy, vec_idx, bit_idx);
        end
        drain();
    endtask

    task automatic test_start_while_busy();
        int hv = 0;
        int i;
        start = 1'b1; n_vec = 8'd2; ps_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1; n_vec = 8'd5;
        tick();
        start = 1'b0; n_vec = 8'd0;
        for (i = 0; i < 100 && !done; i++) begin
            if (out_valid) hv++;
            tick();
        end
        checks++;
        if (hv !== 2 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start got results=%0d done=%b busy=%b want results=2 done=1 busy=0",
                     hv, done, busy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_backpressure();
        test_zero_len();
        test_reset_mid_job();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
